// File: rtl/ram_bank_pkg.sv
// Shared definitions for the ram_bank data store: op encodings and default geometry.
package ram_bank_pkg;

  typedef enum logic [1:0] {
    OpRead = 2'b00,
    OpLoad = 2'b01,
    OpInc  = 2'b10,
    OpClr  = 2'b11
  } op_e;

  localparam int unsigned DefaultWidth = 16;
  localparam int unsigned DefaultDepth = 8;

endpackage

// File: rtl/ram_bank_word_reg.sv
// One WIDTH-bit load register with synchronous active-low reset to zero.
module ram_bank_word_reg #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      q_q <= '0;
    end else if (en_i) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/ram_bank.sv
// Bank of DEPTH word registers with load/increment/clear ops and write-first registered
// readback plus a zero flag.
module ram_bank
  import ram_bank_pkg::*;
#(
  parameter int unsigned WIDTH  = DefaultWidth,
  parameter int unsigned DEPTH  = DefaultDepth,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [WIDTH-1:0]  in_i,
  input  logic [1:0]        op_i,
  input  logic [ADDR_W-1:0] address_i,
  output logic [WIDTH-1:0]  out_o,
  output logic              zero_o
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] wr_en;
  logic [WIDTH-1:0] cur_word;
  logic [WIDTH-1:0] next_word;
  logic             do_write;

  logic [WIDTH-1:0] out_q, out_d;
  logic             zero_q, zero_d;

  assign cur_word = mem[address_i];

  always_comb begin
    next_word = cur_word;
    do_write  = 1'b0;
    unique case (op_e'(op_i))
      OpRead: begin
        next_word = cur_word;
        do_write  = 1'b0;
      end
      OpLoad: begin
        next_word = in_i;
        do_write  = 1'b1;
      end
      OpInc: begin
        next_word = cur_word + WIDTH'(1);
        do_write  = 1'b1;
      end
      OpClr: begin
        next_word = '0;
        do_write  = 1'b1;
      end
      default: begin
        next_word = cur_word;
        do_write  = 1'b0;
      end
    endcase
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_words
    assign wr_en[i] = do_write && (address_i == ADDR_W'(i));

    ram_bank_word_reg #(
      .WIDTH(WIDTH)
    ) u_word (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .en_i  (wr_en[i]),
      .d_i   (next_word),
      .q_o   (mem[i])
    );
  end

  // Readback shows the post-op value of the addressed word, so it follows next_word.
  always_comb begin
    out_d  = next_word;
    zero_d = (next_word == '0);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      out_q  <= '0;
      zero_q <= 1'b1;
    end else begin
      out_q  <= out_d;
      zero_q <= zero_d;
    end
  end

  assign out_o  = out_q;
  assign zero_o = zero_q;

endmodule

// File: doc/ram_bank.md
# ram_bank

Parametrised bank of DEPTH words, each WIDTH bits wide, built from per-word load registers. It is the multi-bit, multi-word successor to the single-bit load register. It adds synchronous active-low clear, in-place increment/clear operations, write-first registered readback and a zero flag. It sits below the CPU datapath as the general-purpose data store and register file.

## Interface
- WIDTH, 16, bits per word; legal range 1..64
- DEPTH, 8, number of words; power of two, at least 2
- ADDR_W, $clog2(DEPTH), derived localparam; not overridden
- clk  input  1  single clock; all state changes on its rising edge
- rst_n  input  1  reset, synchronous and active-low; sampled on the rising edge of clk
- in  input  WIDTH  write data for op LOAD
- op  input  2  operation on the addressed word: 00 READ, 01 LOAD, 10 INC, 11 CLR
- address  input  ADDR_W  selects the word for both the op and the readback
- out  output  WIDTH  registered readback of the addressed word
- zero  output  1  registered; high when out is 0

## Operation
- State: mem[0..DEPTH-1], each WIDTH bits; out register; zero register.
- Reset (rst_n low at an edge): every mem word, and out, go to 0; zero goes to 1. op, in and address are ignored on that edge.
- READ (00): no word changes.
- LOAD (01): mem[address] <= in.
- INC (10): mem[address] <= mem[address] + 1, modulo 2^WIDTH. All-ones wraps to 0; there is no carry output.
- CLR (11): mem[address] <= 0.
- Only the addressed word may change on any edge. All other words hold.
- Readback is write-first:
  - out <= the value mem[address] holds after this edge's op. A LOAD therefore returns in, an INC returns old+1, and a CLR returns 0.
  - zero <= (that same value == 0).
- No read-only cycles exist. Every non-reset edge updates out from the current address, including READ.
- Every address is legal because DEPTH is a power of two; no out-of-range handling is needed.

## Timing
- Write latency is 1 edge: a value applied at edge t is in mem after edge t.
- Read latency is 1 edge: out and zero are valid after edge t for address/op sampled at edge t. Neither output has a combinational path from any input.
- Back-to-back ops on the same address chain without stalls. For example, INC at edge t followed by INC at edge t+1 gives old+2 after edge t+1.
- Reset mid-sequence: the first edge with rst_n low clears everything. The edge after rst_n returns high performs a normal op on the cleared bank.
- No handshake: the block accepts one op per cycle, unconditionally.

## Structure
- Sub-module word_reg: one WIDTH-bit register with synchronous active-low reset to 0 and a load enable. It is the WIDTH-generalised load register.
- ram_bank instantiates DEPTH copies of word_reg through a generate loop. It also contains:
  - an address decoder that gates the load enables
  - a next-value mux: in / word+1 / 0
  - a write-first readback mux
  - the out and zero registers
- Shared header ram_defs.vh holds:
  - op encodings OP_READ=2'b00, OP_LOAD=2'b01, OP_INC=2'b10, OP_CLR=2'b11
  - default WIDTH and DEPTH
- The CPU decoder includes the same header.

## Test plan
- Reset then sweep: hold rst_n low for 1 edge, then READ addresses 0..7 -> out=0 and zero=1 on every cycle.
- Load and isolation: LOAD 16'hA5A5 at address 3, then READ addresses 0..7 -> only address 3 returns A5A5. On the LOAD cycle itself, out is A5A5 and zero is 0.
- Increment wrap: LOAD 16'hFFFE at address 5, then INC, INC, INC -> out steps FFFF, 0000 (zero=1), 0001 (zero=0).
- Clear and chain: LOAD 16'h0010 at address 2, INC, CLR, INC on address 2 -> out 0010, 0011, 0000, 0001.
- Reset mid-operation: load distinct values into all 8 words, then assert rst_n low while op=LOAD with in=16'h1234 -> after that edge out=0. A subsequent READ of every address returns 0, and 1234 is written nowhere.
- Parameter variant: rerun with WIDTH=4, DEPTH=2. LOAD 4'hF at address 1, then INC -> out=0 and zero=1; address 0 is unchanged at 0.
